dmem_ctrl_pipe: RTL and testbench

Parametrised data-memory controller that replaces the fixed single-cycle load/store path with a request/response pipeline. It sits between the CPU load/store unit and an internally inferred word-wide block RAM. It performs byte-lane alignment, byte enables and sign extension, and maps the debug LED register and switch input into the address space. Unlike the current path, it has configurable depth and read latency, explicit error reporting, and an optional two-beat split mode for misaligned accesses.

---
 rtl/dmem_ctrl_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_ctrl_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_pipe.sv
// Data-memory controller: request/response pipeline in front of a byte-lane block RAM.
// Handles lane alignment, sign extension, LED/switch MMIO and optional two-beat misaligned access.
module dmem_ctrl_pipe #(
  parameter int          DEPTH_WORDS      = 8192,
  parameter int          RD_LAT           = 1,
  parameter bit          SPLIT_MISALIGNED = 1'b0,
  parameter logic [31:0] ADRS_LED         = 32'h0000_7f00,
  parameter logic [31:0] ADRS_SW          = 32'h0000_7ff0,
  parameter int          SW_W             = 4
) (
  input  logic            clk_cpu,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_width,
  input  logic            req_signed,
  input  logic [31:0]     req_adrs,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  input  logic [SW_W-1:0] dbg_sw_input,
  output logic [31:0]     dbg_led_q
);
  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [30:0] DEPTH_L = 31'(DEPTH_WORDS);
  localparam logic [30:0] LED_IDX = {1'b0, ADRS_LED[31:2]};
  localparam logic [30:0] SW_IDX  = {1'b0, ADRS_SW[31:2]};

  typedef enum logic {ST_IDLE, ST_BEAT2} state_t;

  state_t state_reg, state_next;

  // request decode
  logic [1:0]  off;
  logic [30:0] w0, w1;
  logic        hit_led, hit_sw, misalign, touch_mmio, range_err, req_err, req_split;
  logic [3:0]  be_base;
  logic [7:0]  be_sh;
  logic [63:0] wdata_sh;

  always_comb begin
    off        = req_adrs[1:0];
    w0         = {1'b0, req_adrs[31:2]};
    w1         = w0 + 31'd1;
    hit_led    = (req_adrs == ADRS_LED);
    hit_sw     = (req_adrs == ADRS_SW);
    misalign   = ((req_width == 2'b00) && (off != 2'b00)) || ((req_width == 2'b01) && off[0]);
    touch_mmio = (w0 == LED_IDX) || (w1 == LED_IDX) || (w0 == SW_IDX) || (w1 == SW_IDX);
    range_err  = (!(hit_led || hit_sw) && (w0 >= DEPTH_L)) || (misalign && (w1 >= DEPTH_L));
    req_err    = (req_width == 2'b11) || range_err ||
                 (misalign && (!SPLIT_MISALIGNED || touch_mmio));
    req_split  = misalign && !req_err;
    case (req_width)
      2'b00:   be_base = 4'b1111;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b0001;
    endcase
    // Upper nibble / upper word carry the lanes that spill into word W+1.
    be_sh    = {4'b0000, be_base} << off;
    wdata_sh = {32'h0, req_wdata} << {off, 3'b000};
  end

  logic          accept, beat2;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] b2_idx_reg;
  logic [3:0]    b2_be_reg;
  logic [31:0]   b2_wdata_reg;

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    accept     = 1'b0;
    beat2      = 1'b0;
    mem_we     = 4'b0000;
    mem_idx    = w0[AW-1:0];
    mem_wdata  = wdata_sh[31:0];
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid && !reset;
        if (accept && req_we && !req_err) mem_we = be_sh[3:0];
        if (accept && req_split) state_next = ST_BEAT2;
      end
      ST_BEAT2: begin
        beat2      = 1'b1;
        mem_idx    = b2_idx_reg;
        mem_wdata  = b2_wdata_reg;
        mem_we     = b2_be_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // One byte-wide RAM per lane; contents are deliberately left uninitialised.
  logic [31:0] rd_word;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] lane_rd_reg;

    always_ff @(posedge clk_cpu) begin
      if (mem_we[gi]) lane_mem[mem_idx] <= mem_wdata[8*gi +: 8];
      lane_rd_reg <= lane_mem[mem_idx];
    end

    assign rd_word[8*gi +: 8] = lane_rd_reg;
  end

  logic            s1_valid_reg, s1_split_reg;
  logic            meta_err_reg, meta_load_reg, meta_sw_reg, meta_signed_reg;
  logic [1:0]      meta_width_reg, meta_off_reg;
  logic [SW_W-1:0] sw_val_reg;
  logic [31:0]     prev_word_reg, led_reg;

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      s1_valid_reg    <= 1'b0;
      s1_split_reg    <= 1'b0;
      meta_err_reg    <= 1'b0;
      meta_load_reg   <= 1'b0;
      meta_sw_reg     <= 1'b0;
      meta_signed_reg <= 1'b0;
      meta_width_reg  <= 2'b00;
      meta_off_reg    <= 2'b00;
      sw_val_reg      <= '0;
      b2_idx_reg      <= '0;
      b2_be_reg       <= 4'b0000;
      b2_wdata_reg    <= 32'h0;
      prev_word_reg   <= 32'h0;
      led_reg         <= 32'h0;
    end else begin
      state_reg    <= state_next;
      s1_valid_reg <= (accept && !req_split) || beat2;
      s1_split_reg <= beat2;
      if (accept) begin
        meta_err_reg    <= req_err;
        meta_load_reg   <= !req_we;
        meta_sw_reg     <= hit_sw && !req_we;
        meta_signed_reg <= req_signed;
        meta_width_reg  <= req_width;
        meta_off_reg    <= off;
        sw_val_reg      <= dbg_sw_input;
        b2_idx_reg      <= w1[AW-1:0];
        b2_be_reg       <= (req_we && req_split) ? be_sh[7:4] : 4'b0000;
        b2_wdata_reg    <= wdata_sh[63:32];
      end
      // Keep beat-1 word while beat 2 reads W+1.
      if (beat2) prev_word_reg <= rd_word;
      if (accept && req_we && !req_err && hit_led) begin
        for (int b = 0; b < 4; b++) begin
          if (be_sh[b]) led_reg[8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign dbg_led_q = led_reg;

  logic [31:0] lo_word, hi_word, shifted, rsp_data_c;

  always_comb begin
    lo_word = s1_split_reg ? prev_word_reg : rd_word;
    hi_word = s1_split_reg ? rd_word : 32'h0;
    shifted = 32'({hi_word, lo_word} >> {meta_off_reg, 3'b000});
    case (meta_width_reg)
      2'b00:   rsp_data_c = shifted;
      2'b01:   rsp_data_c = {{16{meta_signed_reg & shifted[15]}}, shifted[15:0]};
      2'b10:   rsp_data_c = {{24{meta_signed_reg & shifted[7]}}, shifted[7:0]};
      default: rsp_data_c = 32'h0;
    endcase
    if (meta_err_reg || !meta_load_reg) rsp_data_c = 32'h0;
    else if (meta_sw_reg)               rsp_data_c = {{(32-SW_W){1'b0}}, sw_val_reg};
  end

  if (RD_LAT == 2) begin : g_lat2
    logic        v_reg, e_reg;
    logic [31:0] d_reg;

    always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) begin
        v_reg <= 1'b0;
        e_reg <= 1'b0;
        d_reg <= 32'h0;
      end else begin
        v_reg <= s1_valid_reg;
        e_reg <= s1_valid_reg && meta_err_reg;
        d_reg <= s1_valid_reg ? rsp_data_c : 32'h0;
      end
    end

    assign rsp_valid = v_reg;
    assign rsp_err   = e_reg;
    assign rsp_rdata = d_reg;
  end else begin : g_lat1
    assign rsp_valid = s1_valid_reg;
    assign rsp_err   = s1_valid_reg && meta_err_reg;
    assign rsp_rdata = s1_valid_reg ? rsp_data_c : 32'h0;
  end

endmodule

// File: tb/tb_dmem_ctrl_pipe.sv
// Directed bench: instance A (RD_LAT=1, trap misaligned) and B (RD_LAT=2, split misaligned)
// share one request bus; sel routes req_valid and picks which response is observed.
module tb_dmem_ctrl_pipe;
  localparam logic [1:0]  WW = 2'b00, WH = 2'b01, WB = 2'b10;
  localparam logic [31:0] LED = 32'h0000_7f00, SWA = 32'h0000_7ff0;

  logic        clk_cpu = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_width = 2'b00;
  logic [31:0] req_adrs = 32'h0, req_wdata = 32'h0;
  logic [3:0]  sw_in = 4'hA;

  logic        vld_a, vld_b, ready_a, ready_b, rsp_valid_a, rsp_valid_b, rsp_err_a, rsp_err_b;
  logic [31:0] rdata_a, rdata_b, led_a, led_b;
  logic        m_valid, m_err, m_ready;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int last_rlow = 0;

  assign vld_a   = req_valid & ~sel;
  assign vld_b   = req_valid & sel;
  assign m_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign m_err   = sel ? rsp_err_b : rsp_err_a;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_rdata = sel ? rdata_b : rdata_a;

  always #5 clk_cpu = ~clk_cpu;

  dmem_ctrl_pipe #(.RD_LAT(1), .SPLIT_MISALIGNED(1'b0)) u_a (
    .clk_cpu(clk_cpu), .reset(reset), .req_valid(vld_a), .req_ready(ready_a),
    .req_we(req_we), .req_width(req_width), .req_signed(req_signed), .req_adrs(req_adrs),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a), .rsp_err(rsp_err_a),
    .dbg_sw_input(sw_in), .dbg_led_q(led_a));

  dmem_ctrl_pipe #(.RD_LAT(2), .SPLIT_MISALIGNED(1'b1)) u_b (
    .clk_cpu(clk_cpu), .reset(reset), .req_valid(vld_b), .req_ready(ready_b),
    .req_we(req_we), .req_width(req_width), .req_signed(req_signed), .req_adrs(req_adrs),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b), .rsp_err(rsp_err_b),
    .dbg_sw_input(sw_in), .dbg_led_q(led_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] wd, input logic sg,
                       input logic [31:0] adrs, input logic [31:0] wdata);
    req_we = we; req_width = wd; req_signed = sg; req_adrs = adrs; req_wdata = wdata;
    req_valid = 1'b1;
  endtask

  task automatic do_req(input logic we, input logic [1:0] wd, input logic sg,
                        input logic [31:0] adrs, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int rlow);
    @(negedge clk_cpu);
    drive(we, wd, sg, adrs, wdata);
    @(posedge clk_cpu);
    #1 req_valid = 1'b0;
    lat = 0; rlow = 0; rdata = 32'h0; err = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk_cpu);
      if (!m_ready) rlow++;
      if (m_valid) begin
        lat = k; rdata = m_rdata; err = m_err;
      end
    end
  endtask

  task automatic xchk(input string tag, input logic we, input logic [1:0] wd, input logic sg,
                      input logic [31:0] adrs, input logic [31:0] wdata,
                      input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
    logic [31:0] d;
    logic        e;
    int          lat, rlow;
    do_req(we, wd, sg, adrs, wdata, d, e, lat, rlow);
    $display("txn %s dut=%s we=%0b adrs=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             tag, sel ? "B" : "A", we, adrs, wdata, d, e, lat);
    chk({tag, "_rdata"}, d, exp_d);
    chk({tag, "_err"}, 32'(e), 32'(exp_e));
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    last_rlow = rlow;
  endtask

  // Two requests on consecutive edges; responses must arrive on consecutive cycles.
  task automatic pair_chk(input string tag,
                          input logic we0, input logic [1:0] wd0, input logic sg0,
                          input logic [31:0] a0, input logic [31:0] d0, input logic [31:0] e0,
                          input logic we1, input logic [1:0] wd1, input logic sg1,
                          input logic [31:0] a1, input logic [31:0] d1, input logic [31:0] e1,
                          input int lexp);
    logic [31:0] r [2];
    int          c [2];
    int          n;
    n = 0; r[0] = 32'h0; r[1] = 32'h0; c[0] = 0; c[1] = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_cpu);
      if (m_valid && n < 2) begin
        r[n] = m_rdata; c[n] = k; n++;
      end
      if (k == 0)      drive(we0, wd0, sg0, a0, d0);
      else if (k == 1) drive(we1, wd1, sg1, a1, d1);
      else             req_valid = 1'b0;
    end
    $display("txn %s dut=%s rdata0=%h@%0d rdata1=%h@%0d", tag, sel ? "B" : "A", r[0], c[0], r[1], c[1]);
    chk({tag, "_r0"}, r[0], e0);
    chk({tag, "_r1"}, r[1], e1);
    chk({tag, "_c0"}, 32'(c[0]), 32'(lexp));
    chk({tag, "_c1"}, 32'(c[1]), 32'(lexp + 1));
  endtask

  initial begin
    int pulses;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk_cpu);
    chk("rst_ready_a", 32'(ready_a), 32'd1);
    chk("rst_ready_b", 32'(ready_b), 32'd1);
    chk("rst_valid_a", 32'(rsp_valid_a), 32'd0);
    chk("rst_valid_b", 32'(rsp_valid_b), 32'd0);
    chk("rst_rdata_a", rdata_a, 32'h0);
    chk("rst_err_b", 32'(rsp_err_b), 32'd0);
    chk("rst_led_a", led_a, 32'h0);
    chk("rst_led_b", led_b, 32'h0);
    reset = 1'b0;

    // Instance A: RD_LAT=1, misaligned traps
    sel = 1'b0;
    xchk("a_sw_beef", 1, WW, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);
    xchk("a_lb_103", 0, WB, 1, 32'h103, 32'h0, 32'hFFFFFFDE, 0, 1);
    xchk("a_lbu_101", 0, WB, 0, 32'h101, 32'h0, 32'h000000BE, 0, 1);
    pair_chk("a_pair", 0, WB, 1, 32'h103, 32'h0, 32'hFFFFFFDE,
                       0, WB, 0, 32'h101, 32'h0, 32'h000000BE, 1);
    pair_chk("a_raw", 1, WW, 0, 32'h400, 32'h0BADF00D, 32'h0,
                      0, WW, 0, 32'h400, 32'h0, 32'h0BADF00D, 1);
    xchk("a_sw_200", 1, WW, 0, 32'h200, 32'hAABBCCDD, 32'h0, 0, 1);
    xchk("a_sh_202", 1, WH, 0, 32'h202, 32'h00001234, 32'h0, 0, 1);
    xchk("a_lw_200", 0, WW, 0, 32'h200, 32'h0, 32'h1234CCDD, 0, 1);
    xchk("a_lw_101", 0, WW, 0, 32'h101, 32'h0, 32'h0, 1, 1);
    xchk("a_sw_102", 1, WW, 0, 32'h102, 32'h11111111, 32'h0, 1, 1);
    xchk("a_lw_100", 0, WW, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1);
    xchk("a_bad_w", 0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 1, 1);
    xchk("a_sw_led", 1, WW, 0, LED, 32'h5, 32'h0, 0, 1);
    chk("a_led_q", led_a, 32'h5);
    xchk("a_lw_led", 0, WW, 0, LED, 32'h0, 32'h5, 0, 1);
    xchk("a_lb_sw", 0, WB, 1, SWA, 32'h0, 32'h0000000A, 0, 1);
    xchk("a_oor", 0, WW, 0, 32'h8000, 32'h0, 32'h0, 1, 1);

    // Instance B: RD_LAT=2, split misaligned
    sel = 1'b1;
    xchk("b_sw_beef", 1, WW, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2);
    pair_chk("b_pair", 0, WB, 1, 32'h103, 32'h0, 32'hFFFFFFDE,
                       0, WB, 0, 32'h101, 32'h0, 32'h000000BE, 2);
    xchk("b_sw_100", 1, WW, 0, 32'h100, 32'h44332211, 32'h0, 0, 2);
    xchk("b_sw_104", 1, WW, 0, 32'h104, 32'h88776655, 32'h0, 0, 2);
    xchk("b_lw_103", 0, WW, 0, 32'h103, 32'h0, 32'h77665544, 0, 3);
    chk("b_lw_103_rlow", 32'(last_rlow), 32'd1);
    xchk("b_sw_106", 1, WW, 0, 32'h106, 32'hA1B2C3D4, 32'h0, 0, 3);
    chk("b_sw_106_rlow", 32'(last_rlow), 32'd1);
    xchk("b_lw_104", 0, WW, 0, 32'h104, 32'h0, 32'hC3D46655, 0, 2);
    xchk("b_lhu_108", 0, WH, 0, 32'h108, 32'h0, 32'h0000A1B2, 0, 2);
    xchk("b_lh_107", 0, WH, 1, 32'h107, 32'h0, 32'hFFFFB2C3, 0, 3);
    xchk("b_oor_split", 0, WW, 0, 32'h7FFD, 32'h0, 32'h0, 1, 2);
    chk("b_oor_rlow", 32'(last_rlow), 32'd0);
    xchk("b_oor", 0, WW, 0, 32'h8000, 32'h0, 32'h0, 1, 2);

    // Reset during beat 2 of a split store
    xchk("b_sw_300", 1, WW, 0, 32'h300, 32'h11111111, 32'h0, 0, 2);
    xchk("b_sw_304", 1, WW, 0, 32'h304, 32'h22222222, 32'h0, 0, 2);
    xchk("b_sw_led", 1, WW, 0, LED, 32'h77, 32'h0, 0, 2);
    chk("b_led_q", led_b, 32'h77);
    @(negedge clk_cpu);
    drive(1, WW, 0, 32'h302, 32'hAABBCCDD);
    @(posedge clk_cpu);
    #1 req_valid = 1'b0;
    chk("b_beat2_ready", 32'(ready_b), 32'd0);
    reset = 1'b1;
    #1;
    chk("b_rst_ready", 32'(ready_b), 32'd1);
    pulses = 0;
    repeat (3) begin
      @(negedge clk_cpu);
      if (rsp_valid_b) pulses++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk_cpu);
      if (rsp_valid_b) pulses++;
    end
    $display("txn b_rst_beat2 dut=B pulses=%0d led=%h ready=%0b", pulses, led_b, ready_b);
    chk("b_rst_pulses", 32'(pulses), 32'd0);
    chk("b_rst_led", led_b, 32'h0);
    chk("b_rst_ready_after", 32'(ready_b), 32'd1);
    chk("a_rst_led", led_a, 32'h0);
    xchk("b_lw_300", 0, WW, 0, 32'h300, 32'h0, 32'hCCDD1111, 0, 2);
    xchk("b_lw_304", 0, WW, 0, 32'h304, 32'h0, 32'h22222222, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
